// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises three coin-sensor lines, debounces them and emits one pulse per coin.
// Optional accepted-coin counter enabled by defining COIN_ACCEPTOR_COUNT_EN.
//
// state      | meaning
// IDLE       | waiting for a synced line to go high
// DEBOUNCE   | one coin latched, counting consecutive clean cycles
// EMIT       | one-cycle accepted-coin pulse
// REJECT     | one-cycle invalid-coin pulse
// RELEASE    | waiting for all lines low for DEBOUNCE_CYCLES cycles
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_nickel,
    input  logic       raw_dime,
    input  logic       raw_quarter,
    output logic       nickel,
    output logic       dime,
    output logic       quarter,
    output logic       reject,
    output logic       busy,
    output logic [7:0] coin_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_EMIT     = 3'd2,
        S_REJECT   = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    // Line vectors are ordered {nickel, dime, quarter}.
    logic [2:0] sync_1;
    logic [2:0] sync_2;
    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [2:0] coin;
    logic [2:0] coin_nx;
    logic [7:0] cnt_inc;
    logic       single_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {raw_nickel, raw_dime, raw_quarter};
            sync_2 <= sync_1;
        end
    end

    assign cnt_inc    = cnt + 8'd1;
    assign single_hot = (sync_2 != 3'b000) && ((sync_2 & (sync_2 - 3'd1)) == 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            coin  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            coin  <= coin_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        coin_nx  = coin;
        unique case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (single_hot) begin
                    coin_nx  = sync_2;
                    state_nx = S_DEBOUNCE;
                end else if (sync_2 != 3'b000) begin
                    state_nx = S_REJECT;
                end
            end
            S_DEBOUNCE: begin
                if ((sync_2 & ~coin) != 3'b000) begin
                    state_nx = S_REJECT;
                    cnt_nx   = '0;
                end else if ((sync_2 & coin) == 3'b000) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    coin_nx  = '0;
                end else if (cnt_inc >= DB_LIMIT) begin
                    state_nx = S_EMIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_EMIT: begin
                state_nx = S_RELEASE;
                cnt_nx   = '0;
            end
            S_REJECT: begin
                state_nx = S_RELEASE;
                cnt_nx   = '0;
            end
            S_RELEASE: begin
                if (sync_2 != 3'b000) begin
                    cnt_nx = '0;
                end else if (cnt_inc >= DB_LIMIT) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    coin_nx  = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                coin_nx  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so the pulse lines up with the EMIT/REJECT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickel  <= 1'b0;
            dime    <= 1'b0;
            quarter <= 1'b0;
            reject  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            nickel  <= (state_nx == S_EMIT) && coin_nx[2];
            dime    <= (state_nx == S_EMIT) && coin_nx[1];
            quarter <= (state_nx == S_EMIT) && coin_nx[0];
            reject  <= (state_nx == S_REJECT);
            busy    <= (state_nx != S_IDLE);
        end
    end

`ifdef COIN_ACCEPTOR_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if ((state_nx == S_EMIT) && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign coin_count = count_q;
`else
    assign coin_count = 8'd0;
`endif

endmodule
